// File: rtl/serial_comperator.sv
// Bit-serial magnitude comparator: walks both operands MSB first, one bit per clock,
// and reports one-hot greater/less/equal flags with a start/busy/done handshake.
module serial_comperator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             l,
    output logic             e
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             decided_q, decided_d;
    logic             a_gt_q, a_gt_d;
    logic             g_q, g_d;
    logic             l_q, l_d;
    logic             e_q, e_d;

    logic bit_a, bit_b, first_bit, a_wins_bit, dec_now, gt_now;

    assign bit_a     = sa_q[WIDTH-1];
    assign bit_b     = sb_q[WIDTH-1];
    assign first_bit = (cnt_q == CW'(WIDTH - 1));
    // In two's complement only the sign position inverts the sense of a set bit.
    assign a_wins_bit = (sgn_q && first_bit) ? bit_b : bit_a;
    assign dec_now    = decided_q | (bit_a ^ bit_b);
    assign gt_now     = decided_q ? a_gt_q : a_wins_bit;

    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        decided_d = decided_q;
        a_gt_d    = a_gt_q;
        g_d       = g_q;
        l_d       = l_q;
        e_d       = e_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sa_d      = a;
                    sb_d      = b;
                    sgn_d     = mode_signed;
                    decided_d = 1'b0;
                    a_gt_d    = 1'b0;
                    cnt_d     = CW'(WIDTH - 1);
                    state_d   = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sa_d      = sa_q << 1;
                sb_d      = sb_q << 1;
                decided_d = dec_now;
                a_gt_d    = gt_now;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    g_d     = dec_now & gt_now;
                    l_d     = dec_now & ~gt_now;
                    e_d     = ~dec_now;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            decided_q <= 1'b0;
            a_gt_q    <= 1'b0;
            g_q       <= 1'b0;
            l_q       <= 1'b0;
            e_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            decided_q <= decided_d;
            a_gt_q    <= a_gt_d;
            g_q       <= g_d;
            l_q       <= l_d;
            e_q       <= e_d;
        end
    end

    assign busy = (state_q == S_RUN) || (state_q == S_DONE);
    assign done = (state_q == S_DONE);
    assign g    = g_q;
    assign l    = l_q;
    assign e    = e_q;

endmodule

// File: doc/serial_comperator.md
Name: serial_comperator

Overview:
- Parametrised, sequential successor to the team's combinational greater/less/equal comparator.
- Compares two WIDTH-bit operands bit-serially, MSB first, one bit per clock, using a start/busy/done handshake.
- Selectable signed (two's complement) or unsigned mode per operation.
- Used where operand width makes a flat compare too slow or too large, e.g. sorters and threshold checkers on the datapath.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a compare; sampled only in IDLE or DONE
mode_signed  input  1  1 = two's complement compare, 0 = unsigned; captured with start
a  input  WIDTH  operand A; captured with start
b  input  WIDTH  operand B; captured with start
busy  output  1  high while an operation is in progress (RUN or DONE)
done  output  1  one-cycle pulse; g/l/e are valid in this cycle
g  output  1  A > B (registered, held)
l  output  1  A < B (registered, held)
e  output  1  A == B (registered, held)

Behaviour:
- Reset:
  - rst is sampled on the rising clk edge and overrides all other inputs.
  - After reset: state IDLE, busy=0, done=0, g=0, l=0, e=0, internal shift registers and bit counter cleared.
- States:
  - IDLE: start=1 -> capture a, b, mode_signed into shift registers; clear decided flag; counter=WIDTH-1; go to RUN.
  - RUN: each edge processes the current MSB of both shift registers, shifts left by one and decrements the counter. When the counter reaches 0 on a processing edge, go to DONE.
  - DONE: lasts exactly one cycle. start=1 -> capture new operands and go to RUN (back-to-back); else go to IDLE.
- Decision rule:
  - Once decided=1, later bits are ignored.
  - First differing bit sets decided=1 and the winner. Unsigned: the operand with 1 is greater.
  - Signed mode, MSB position only: the operand with 1 is LESS.
  - No difference after all WIDTH bits -> equal.
- Latency:
  - Capture edge E0; bits processed on edges E1..EWIDTH.
  - g/l/e are updated and done=1 during the cycle after EWIDTH, i.e. WIDTH+1 cycles after start is sampled.
  - Throughput: one result per WIDTH+1 cycles with start held high.
- Outputs:
  - busy=1 from the cycle after capture through the DONE cycle inclusive.
  - done is high only in DONE.
  - g/l/e change only on entry to DONE; they are one-hot thereafter and hold their value until the next DONE.
- Ignored inputs:
  - start in RUN is ignored; no queueing, no error.
  - a, b and mode_signed changes after capture do not affect the running operation.
- Reset mid-operation: aborts immediately. No done pulse; g/l/e return to 0.
- Simultaneous rst and start: rst wins; start is dropped.

Test Plan:
- WIDTH=4, unsigned, a=4'b1010, b=4'b0111, start one cycle -> busy high 5 cycles, done pulse in 5th cycle after start edge, g=1 l=0 e=0.
- WIDTH=4, signed, a=4'b1110 (-2), b=4'b0001 (+1) -> l=1; same operands unsigned -> g=1.
- WIDTH=8, a=b=8'hA5 -> e=1 after 9 cycles; then a=8'h00, b=8'hFF unsigned -> l=1; g/l/e hold between dones.
- Start held high for 3 operations (WIDTH=4: 5>3, 2<9, 6==6) -> done pulses exactly 5 cycles apart, results g, l, e in order; busy never drops.
- During RUN, toggle start, a and b every cycle -> result reflects captured operands only; single done pulse.
- Assert rst in 2nd RUN cycle -> next cycle busy=0, done=0, g=l=e=0; no done pulse follows. Also check that rst and start asserted together leaves the block in IDLE.
